// File: rtl/hybrid_sched_pkg.sv
// Shared definitions for the approximate-adder scheduler.
//   state_e  : scheduler FSM encoding (IDLE, EXEC, RESP)
//   CNT_W    : width of the saturating operation/error counters
//   CNT_MAX  : saturation value of those counters
//   id_width : requester-index width, clog2 with a floor of 1 bit
package hybrid_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/HybridAdder.sv
// Approximate adder core: exact N1-bit upper segment, approximate N2-bit
// lower segment (lower-part OR adder).
//   a_i, b_i : W-bit operands (W = N1+N2)
//   sum_o    : W-bit approximate sum
//   cout_o   : carry out of the upper segment
module HybridAdder #(
    parameter int N1 = 16,
    parameter int N2 = 16
) (
    input  logic [N1+N2-1:0] a_i,
    input  logic [N1+N2-1:0] b_i,
    output logic [N1+N2-1:0] sum_o,
    output logic             cout_o
);

    localparam int W = N1 + N2;

    logic [N2-1:0] lo_sum;
    logic          lo_carry;
    logic [N1:0]   hi_sum;

    // Lower bits are OR-ed instead of added; the only carry passed upward is
    // the AND of the two lower-segment MSBs, so long carry chains are lost.
    assign lo_sum   = a_i[N2-1:0] | b_i[N2-1:0];
    assign lo_carry = a_i[N2-1] & b_i[N2-1];
    assign hi_sum   = {1'b0, a_i[W-1:N2]} + {1'b0, b_i[W-1:N2]} + {{N1{1'b0}}, lo_carry};

    assign sum_o  = {hi_sum[N1-1:0], lo_sum};
    assign cout_o = hi_sum[N1];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The grant pointer is held by the caller.
//   req_i        : request vector
//   last_grant_i : index granted most recently; search starts one above it
//   grant_o      : one-hot grant (all zero when no request)
//   grant_idx_o  : encoded index of grant_o
//   any_o        : at least one request present
module rr_arbiter
    import hybrid_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   grant_idx_o,
    output logic            any_o
);

    int            idx;
    logic [IW-1:0] idx_w;
    logic          found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = |req_i;
        found       = 1'b0;
        idx         = 0;
        idx_w       = '0;
        // Walk last_grant+1 .. last_grant+NREQ, wrapping modulo NREQ;
        // the last candidate is last_grant itself.
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last_grant_i) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_w = IW'(idx);
            if (!found && req_i[idx_w]) begin
                found          = 1'b1;
                grant_o[idx_w] = 1'b1;
                grant_idx_o    = idx_w;
            end
        end
    end

endmodule

// File: rtl/hybrid_adder_sched.sv
// Time-shares one HybridAdder among NREQ requesters with round-robin grant,
// tags each result with the requester id, and monitors accuracy against an
// exact adder with saturating operation and error counters.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot pulse)
//   req_a, req_b          : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready   : response handshake
//   rsp_sum/cout/id/err   : approximate result, carry, requester id, error flag
//   op_cnt, err_cnt       : saturating completed-response / error counters
//   cnt_clr               : synchronous clear of both counters
//   dbg_state             : current FSM state for observation
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Requesters hold req_valid and operands stable until their
// req_ready pulse; rsp_* stays stable while rsp_valid is high and rsp_ready low.
module hybrid_adder_sched
    import hybrid_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int N1   = 16,
    parameter  int N2   = 16,
    localparam int W    = N1 + N2,
    localparam int IW   = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [IW-1:0]     rsp_id,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  op_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              cnt_clr,
    output logic [1:0]        dbg_state
);

    state_e           state_q, state_d;
    logic [IW-1:0]    last_grant_q, last_grant_d;
    logic [W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [IW-1:0]    op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_err_q, rsp_err_d;
    logic [IW-1:0]    rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d, err_cnt_q, err_cnt_d;

    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    grant_idx;
    logic             any_req;
    logic [W-1:0]     core_sum;
    logic             core_cout;
    logic [W:0]       exact_sum;
    logic             core_err;
    logic             rsp_hs;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .any_o        (any_req)
    );

    HybridAdder #(.N1(N1), .N2(N2)) u_core (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .sum_o  (core_sum),
        .cout_o (core_cout)
    );

    assign exact_sum = {1'b0, op_a_q} + {1'b0, op_b_q};
    assign core_err  = (exact_sum != {core_cout, core_sum});

    // Gated by rst_n so no accept pulse leaks out while reset is held.
    assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_err_d    = rsp_err_q;
        rsp_id_d     = rsp_id_q;
        op_cnt_d     = op_cnt_q;
        err_cnt_d    = err_cnt_q;
        rsp_hs       = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    op_a_d       = req_a[int'(grant_idx)*W +: W];
                    op_b_d       = req_b[int'(grant_idx)*W +: W];
                    op_id_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_sum_d   = core_sum;
                rsp_cout_d  = core_cout;
                rsp_err_d   = core_err;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_hs      = 1'b1;
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear takes priority over a same-cycle increment.
        if (cnt_clr) begin
            op_cnt_d  = '0;
            err_cnt_d = '0;
        end else if (rsp_hs) begin
            if (op_cnt_q != CNT_MAX) begin
                op_cnt_d = op_cnt_q + 1'b1;
            end
            if (rsp_err_q && err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NREQ - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= '0;
            op_cnt_q     <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_err_q    <= rsp_err_d;
            rsp_id_q     <= rsp_id_d;
            op_cnt_q     <= op_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_id    = rsp_id_q;
    assign op_cnt    = op_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hybrid_adder_sched.sv
// Directed bench for hybrid_adder_sched (NREQ=4, N1=N2=16).
// Inputs are driven 1 time unit after the rising edge; combinational
// req_ready is sampled 1 unit later, registered outputs right after driving.
module tb_hybrid_adder_sched;

    localparam int NREQ = 4;
    localparam int N1   = 16;
    localparam int N2   = 16;
    localparam int W    = 32;
    localparam int IW   = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [IW-1:0]     rsp_id;
    logic              rsp_err;
    logic [15:0]       op_cnt;
    logic [15:0]       err_cnt;
    logic              cnt_clr;
    logic [1:0]        dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hybrid_adder_sched #(.NREQ(NREQ), .N1(N1), .N2(N2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .op_cnt    (op_cnt),
        .err_cnt   (err_cnt),
        .cnt_clr   (cnt_clr),
        .dbg_state (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Entered and left 1 unit after a rising edge, in IDLE.
    task automatic send_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic clr, output logic [W-1:0] s, output logic c,
                           output logic e, output logic [IW-1:0] rid, output logic ok);
        int   n;
        logic got;
        s   = '0;
        c   = 1'b0;
        e   = 1'b0;
        rid = '0;
        ok  = 1'b0;
        got = 1'b0;
        n   = 0;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid        = '0;
        req_valid[id]    = 1'b1;
        rsp_ready        = 1'b1;
        while (!got && n < 8) begin
            #1 got = req_ready[id];
            @(posedge clk);
            #1 n++;
        end
        req_valid = '0;
        if (got) begin
            got = 1'b0;
            n   = 0;
            while (!got && n < 8) begin
                if (rsp_valid) begin
                    got     = 1'b1;
                    s       = rsp_sum;
                    c       = rsp_cout;
                    e       = rsp_err;
                    rid     = rsp_id;
                    cnt_clr = clr;
                    @(posedge clk);
                    #1 cnt_clr = 1'b0;
                end else begin
                    @(posedge clk);
                    #1 n++;
                end
            end
            ok = got;
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        total++; if ({rsp_sum, rsp_cout, rsp_id, rsp_err} !== 36'h0) begin bad++; $display("FAIL rst_rsp_data: got %h/%b/%0d/%b want 0", rsp_sum, rsp_cout, rsp_id, rsp_err); end
        total++; if (op_cnt !== 16'h0 || err_cnt !== 16'h0) begin bad++; $display("FAIL rst_counters: got %h/%h want 0/0", op_cnt, err_cnt); end
        total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", dbg_state, S_IDLE); end
        req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0 || dbg_state !== S_IDLE) begin bad++; $display("FAIL rst_idle_after: got valid=%b state=%0d want 0/%0d", rsp_valid, dbg_state, S_IDLE); end
    endtask

    task automatic test_single();
        apply_reset();
        req_a[31:0] = 32'h0001_0000;
        req_b[31:0] = 32'h0002_0000;
        req_valid   = 4'b0001;
        rsp_ready   = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        @(posedge clk);
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_pulse: got %b want 0000", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
        req_valid = '0;
        @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_latency: got %b want 1", rsp_valid); end
        total++; if (rsp_sum !== 32'h0003_0000) begin bad++; $display("FAIL single_sum: got %h want 00030000", rsp_sum); end
        total++; if ({rsp_cout, rsp_id, rsp_err} !== 4'b0_00_0) begin bad++; $display("FAIL single_flags: got cout=%b id=%0d err=%b want 0/0/0", rsp_cout, rsp_id, rsp_err); end
        @(posedge clk);
        #1;
        total++; if (op_cnt !== 16'd1 || err_cnt !== 16'd0) begin bad++; $display("FAIL single_counts: got %0d/%0d want 1/0", op_cnt, err_cnt); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop: got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int              exp_gnt[5];
        logic [W-1:0]    exp_sum[4];
        logic [NREQ-1:0] oh;
        int              g;
        int              r;
        exp_gnt = '{0, 1, 2, 3, 0};
        exp_sum = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
        g = 0;
        r = 0;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = i * 32'h0001_0000;
            req_b[i*W +: W] = 32'h0001_0000;
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            #1;
            if (req_ready !== 4'b0000 && g < 5) begin
                oh = '0;
                oh[exp_gnt[g]] = 1'b1;
                total++; if (req_ready !== oh) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, oh); end
                total++; if (cyc != 3 * g) begin bad++; $display("FAIL rr_grant_cycle%0d: got %0d want %0d", g, cyc, 3 * g); end
                g++;
            end
            if (rsp_valid === 1'b1 && r < 5) begin
                total++; if (rsp_id !== IW'(exp_gnt[r])) begin bad++; $display("FAIL rr_rsp_id%0d: got %0d want %0d", r, rsp_id, exp_gnt[r]); end
                total++; if (rsp_sum !== exp_sum[exp_gnt[r]]) begin bad++; $display("FAIL rr_rsp_sum%0d: got %h want %h", r, rsp_sum, exp_sum[exp_gnt[r]]); end
                total++; if (cyc != 3 * r + 2) begin bad++; $display("FAIL rr_rsp_cycle%0d: got %0d want %0d", r, cyc, 3 * r + 2); end
                r++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        total++; if (g != 5 || r != 5) begin bad++; $display("FAIL rr_count: got grants=%0d rsps=%0d want 5/5", g, r); end
        total++; if (op_cnt !== 16'd5) begin bad++; $display("FAIL rr_op_cnt: got %0d want 5", op_cnt); end
    endtask

    task automatic test_backpressure();
        // last_grant is 0 here, so requester 2 alone is picked.
        req_a[2*W +: W] = 32'h0000_1234;
        req_b[2*W +: W] = 32'h0001_0000;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
        @(posedge clk);
        #1 req_valid = 4'b1011;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            #1;
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_no_grant%0d: got %b want 0000", k, req_ready); end
            total++; if ({rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_err} !== {1'b1, 32'h0001_1234, 1'b0, 2'd2, 1'b0})
                begin bad++; $display("FAIL bp_hold%0d: got v=%b sum=%h c=%b id=%0d e=%b want 1/00011234/0/2/0", k, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_err); end
            @(posedge clk);
        end
        #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        total++; if (dbg_state !== S_IDLE || rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got state=%0d valid=%b want %0d/0", dbg_state, rsp_valid, S_IDLE); end
        total++; if (op_cnt !== 16'd6) begin bad++; $display("FAIL bp_op_cnt: got %0d want 6", op_cnt); end
    endtask

    task automatic test_error_accounting();
        logic [W-1:0]  va[4];
        logic [W-1:0]  vb[4];
        logic [W-1:0]  vs[4];
        logic          vc[4];
        logic          ve[4];
        logic [15:0]   ecnt[4];
        logic [W-1:0]  s;
        logic          c;
        logic          e;
        logic [IW-1:0] rid;
        logic          ok;
        va   = '{32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_8000, 32'h1234_5678};
        vb   = '{32'h0000_0001, 32'hFFFF_0000, 32'h0000_8000, 32'h0000_0000};
        vs   = '{32'h0000_FFFF, 32'hFFFE_0000, 32'h0001_8000, 32'h1234_5678};
        vc   = '{1'b0, 1'b1, 1'b0, 1'b0};
        ve   = '{1'b1, 1'b0, 1'b1, 1'b0};
        ecnt = '{16'd1, 16'd1, 16'd2, 16'd2};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            send_op(k, va[k], vb[k], 1'b0, s, c, e, rid, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL err_timeout%0d: got %b want 1", k, ok); end
            total++; if ({s, c, e} !== {vs[k], vc[k], ve[k]}) begin bad++; $display("FAIL err_vec%0d: got %h/%b/%b want %h/%b/%b", k, s, c, e, vs[k], vc[k], ve[k]); end
            total++; if (rid !== IW'(k)) begin bad++; $display("FAIL err_id%0d: got %0d want %0d", k, rid, k); end
            total++; if (err_cnt !== ecnt[k]) begin bad++; $display("FAIL err_cnt%0d: got %0d want %0d", k, err_cnt, ecnt[k]); end
        end
        total++; if (op_cnt !== 16'd4) begin bad++; $display("FAIL err_op_cnt: got %0d want 4", op_cnt); end
    endtask

    task automatic test_counter_bounds();
        logic [W-1:0]  s;
        logic          c;
        logic          e;
        logic [IW-1:0] rid;
        logic          ok;
        // Preload instead of running 65536 real operations.
        force dut.op_cnt_q  = 16'hFFFE;
        force dut.err_cnt_q = 16'hFFFF;
        #1;
        release dut.op_cnt_q;
        release dut.err_cnt_q;
        send_op(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, s, c, e, rid, ok);
        total++; if (ok !== 1'b1 || op_cnt !== 16'hFFFF || err_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_reach_max: got ok=%b %h/%h want 1 FFFF/FFFF", ok, op_cnt, err_cnt); end
        send_op(2, 32'h0000_FFFF, 32'h0000_0001, 1'b0, s, c, e, rid, ok);
        total++; if (ok !== 1'b1 || op_cnt !== 16'hFFFF || err_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_saturate: got ok=%b %h/%h want 1 FFFF/FFFF", ok, op_cnt, err_cnt); end
        send_op(3, 32'h0000_FFFF, 32'h0000_0001, 1'b1, s, c, e, rid, ok);
        total++; if (ok !== 1'b1 || op_cnt !== 16'h0 || err_cnt !== 16'h0) begin bad++; $display("FAIL cnt_clr_wins: got ok=%b %h/%h want 1 0000/0000", ok, op_cnt, err_cnt); end
    endtask

    task automatic test_reset_in_exec();
        logic [W-1:0]  s;
        logic          c;
        logic          e;
        logic [IW-1:0] rid;
        logic          ok;
        apply_reset();
        send_op(3, 32'h0000_0001, 32'h0000_0002, 1'b0, s, c, e, rid, ok);
        total++; if (ok !== 1'b1 || op_cnt !== 16'd1) begin bad++; $display("FAIL rex_setup: got ok=%b op_cnt=%0d want 1/1", ok, op_cnt); end
        req_a[1*W +: W] = 32'h0000_0005;
        req_b[1*W +: W] = 32'h0000_0003;
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rex_grant1: got %b want 0010", req_ready); end
        @(posedge clk);
        #1;
        total++; if (dbg_state !== S_EXEC) begin bad++; $display("FAIL rex_in_exec: got %0d want %0d", dbg_state, S_EXEC); end
        req_a[0 +: W] = 32'h0001_0000;
        req_b[0 +: W] = 32'h0000_0002;
        req_valid = 4'b0011;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_err} !== 41'h0) begin bad++; $display("FAIL rex_outputs: got rdy=%b v=%b sum=%h c=%b id=%0d e=%b want all 0", req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_err); end
        total++; if (op_cnt !== 16'h0 || err_cnt !== 16'h0 || dbg_state !== S_IDLE) begin bad++; $display("FAIL rex_state: got %h/%h/%0d want 0/0/%0d", op_cnt, err_cnt, dbg_state, S_IDLE); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rex_grant0: got %b want 0001", req_ready); end
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rex_no_stale: got %b want 0", rsp_valid); end
        @(posedge clk);
        #1;
        total++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd0, 32'h0001_0002}) begin bad++; $display("FAIL rex_rsp: got v=%b id=%0d sum=%h want 1/0/00010002", rsp_valid, rsp_id, rsp_sum); end
        @(posedge clk);
        #1;
        total++; if (op_cnt !== 16'd1) begin bad++; $display("FAIL rex_op_cnt: got %0d want 1", op_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_error_accounting();
        test_counter_bounds();
        test_reset_in_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/hybrid_adder_sched.md
# hybrid_adder_sched

Time-shares one `HybridAdder` core among `NREQ` requesters. Each requester presents a W-bit operand pair under a valid/ready handshake, and the block grants requesters round-robin. It returns the approximate sum tagged with the requester index. In parallel it computes the exact sum and keeps saturating operation and error counters for on-line accuracy monitoring. It sits between client datapaths and the single approximate adder instance.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `N1`, default 16: width of the exact upper segment.
- `N2`, default 16: width of the approximate lower segment. W = N1+N2.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: per-requester operand valid.
- `req_ready` out NREQ: one-hot accept pulse.
- `req_a` in NREQ*W: operand A, requester i at bits [i*W +: W].
- `req_b` in NREQ*W: operand B, same packing.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_sum` out W: approximate sum from the core.
- `rsp_cout` out 1: carry-out from the core.
- `rsp_id` out clog2(NREQ): index of the granted requester.
- `rsp_err` out 1: 1 when {rsp_cout, rsp_sum} differs from the exact A+B (W+1 bits).
- `op_cnt` out 16: completed responses, saturating.
- `err_cnt` out 16: responses with rsp_err=1, saturating.
- `cnt_clr` in 1: synchronous clear of both counters.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE:**
  - If any `req_valid` is high, grant the first valid requester scanning from `last_grant`+1, wrapping modulo NREQ.
  - In the same cycle, assert `req_ready` for that requester only and latch its A, B and id into operand registers.
  - Update `last_grant` and go to EXEC.
  - If no `req_valid` is high, stay in IDLE.
- **EXEC:**
  - The operand registers drive the core combinationally.
  - Register sum, cout and err into the response registers, then go to RESP.
  - The exact sum is the (W+1)-bit `A+B` of the operand registers.
- **RESP:**
  - `rsp_valid`=1. All response outputs stay stable until `rsp_ready`=1.
  - On the handshake: return to IDLE, increment `op_cnt`, and increment `err_cnt` if `rsp_err`=1.
- `req_ready` is 0 in EXEC and RESP. Requesters must keep `req_valid` and their operands stable until accepted.
- Counters saturate at 0xFFFF.
- `cnt_clr` wins over a same-cycle increment: the counter becomes 0.
- `last_grant` resets to NREQ-1, so requester 0 has first priority after reset.
- A requester dropping `req_valid` before grant is legal and is simply not granted.

## Timing
- Reset (async assert, sync deassert by the system) sets:
  - state=IDLE
  - all `req_ready`=0, `rsp_valid`=0
  - `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0, `rsp_err`=0
  - `op_cnt`=0, `err_cnt`=0, `last_grant`=NREQ-1
- Reset mid-operation discards the in-flight transaction without a response and leaves counters at 0.
- Latency: accept at cycle T (`req_ready` high) gives `rsp_valid` at T+2.
- With `rsp_ready` tied high, throughput is one op per 3 cycles.
- Backpressure: RESP holds indefinitely and no new grant is issued.
- All outputs are registered except `req_ready`, which is decoded from the IDLE state and the arbiter grant.

## Structure
- Package `hybrid_sched_pkg` holds:
  - the state enum {IDLE, EXEC, RESP}
  - localparam `CNT_W`=16 and `CNT_MAX`
  - a function for the id width, clog2 with a minimum of 1
- Sub-module `rr_arbiter`, parameterised by NREQ:
  - inputs: request vector, `last_grant`
  - outputs: one-hot grant, encoded index, any-request flag
  - purely combinational; the pointer lives in the scheduler.
- Exactly one `HybridAdder #(N1,N2)` instance.
- The exact adder is an inline `+` used only for the error flag.

## Test plan
- **Single request, no carry.** Reset, then `req_valid`=0001 with A=0x0001_0000, B=0x0002_0000.
  - `req_ready`=0001 for 1 cycle.
  - Two cycles later, `rsp_valid` with `rsp_sum`=0x0003_0000, `rsp_cout`=0, `rsp_id`=0, `rsp_err`=0.
  - `op_cnt`=1 after the handshake.
- **Round-robin fairness.** All four `req_valid` held high continuously with `rsp_ready`=1.
  - Grant order is 0,1,2,3,0.
  - `rsp_id` follows the same sequence, one response every 3 cycles.
- **Backpressure.** `rsp_ready`=0 for 10 cycles in RESP.
  - `rsp_*` stay stable and no `req_ready` is asserted.
  - Releasing `rsp_ready` gives IDLE the next cycle.
- **Error accounting.**
  - Stimulus: operands with a lower-segment carry chain, A=0x0000_FFFF, B=0x0000_0001.
  - `rsp_err` must equal (core-model result != 0x0_0001_0000).
  - `err_cnt` increments only when `rsp_err`=1.
  - Overflow top carry: A=B=0xFFFF_0000 gives `rsp_cout`=1.
- **Counter boundaries.**
  - Force 65536 ops: `op_cnt` holds 0xFFFF.
  - `cnt_clr` asserted in the same cycle as a response handshake: both counters read 0 next cycle.
- **Reset in EXEC.** Assert `rst_n`=0 asynchronously.
  - All outputs are 0 immediately.
  - After release, requester 0 is granted first and no stale response appears.
